signed_divider: RTL and testbench
=================================

SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 Parameter WIDTH, default 8: operand, quotient and remainder width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; returns the block to IDLE.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  WIDTH  two's-complement dividend; sampled with start.
REQ-006 divisor  input  WIDTH  two's-complement divisor; sampled with start.
REQ-007 quotient  output  WIDTH  two's-complement quotient, held until the next accepted start.
REQ-008 remainder  output  WIDTH  two's-complement remainder, held until the next accepted start.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  high for exactly one cycle when results become valid.
REQ-011 div_by_zero  output  1  error flag for the current result, held with the result.
REQ-012 overflow  output  1  error flag for the current result, held with the result.

Function
REQ-013 States: IDLE, DIVIDE, FIXUP, DONE.
REQ-014 IDLE, start=1, divisor!=0 -> DIVIDE; the same edge latches |dividend|, |divisor|, both operand signs and the raw dividend, loads iteration counter = WIDTH-1, and clears the partial remainder and all flags.
REQ-015 IDLE, start=1, divisor==0 -> DONE; the same edge sets quotient = all ones, remainder = dividend, div_by_zero = 1, overflow = 0.
REQ-016 DIVIDE: restoring shift-subtract, one quotient bit per cycle, MSB first, using a WIDTH+1-bit partial remainder so that the magnitude -2^(WIDTH-1) is handled without loss.
REQ-017 DIVIDE: counter decrements each cycle; when the counter is 0 the next state is FIXUP, giving exactly WIDTH DIVIDE cycles.
REQ-018 FIXUP, one cycle: quotient is negated if the operand signs differ; remainder is negated if the dividend is negative; next state is DONE.
REQ-019 Rounding: quotient truncates toward zero; a nonzero remainder takes the dividend's sign; quotient*divisor + remainder == dividend for every non-error case.
REQ-020 Overflow case dividend = -2^(WIDTH-1), divisor = -1: quotient = -2^(WIDTH-1) (wrapped), remainder = 0, overflow = 1.
REQ-021 DONE: done = 1 for one cycle; next state is IDLE unconditionally.
REQ-022 Latency: for a nonzero divisor, done is high during the cycle after the (WIDTH+1)th rising edge following the edge that sampled start (cycle 10 for WIDTH=8); for a zero divisor, done is high in the cycle immediately after the start edge.
REQ-023 start while busy is ignored; the in-flight operation is unaffected and no request is queued.
REQ-024 start in the same cycle as DONE is ignored; start is accepted only once the state is IDLE.
REQ-025 quotient, remainder, div_by_zero and overflow change only on an accepted start or at FIXUP/DONE entry; they are otherwise stable.

Reset
REQ-026 Reset, asynchronously: state = IDLE; quotient, remainder, counter and partial remainder = 0; busy, done, div_by_zero and overflow = 0.
REQ-027 Reset mid-operation abandons the division; no done pulse is produced for it, and the next start after reset deassertion is accepted normally.

Structure
REQ-028 A shared package div_pkg holds the state enum typedef div_state_t and a localparam DIV_WIDTH_DEFAULT = 8.
REQ-029 The control FSM and counter reside in signed_divider.
REQ-030 The shift/subtract datapath (partial remainder, quotient shift register, WIDTH+1-bit subtractor, negation logic) is one sub-module, div_datapath, driven by control bits from the FSM.

Verification
REQ-031 100 / 7 -> quotient 14 (0x0E), remainder 2, flags 0, done in cycle 10 after the start edge.
REQ-032 -100 / 7 -> quotient 0xF2 (-14), remainder 0xFE (-2); and 100 / -7 -> quotient 0xF2, remainder 0x02.
REQ-033 -128 / -1 -> quotient 0x80, remainder 0x00, overflow = 1; and -128 / 1 -> quotient 0x80, overflow = 0.
REQ-034 5 / 0 -> quotient 0xFF, remainder 0x05, div_by_zero = 1, done in the cycle after the start edge.
REQ-035 Start 100 / 7, pulse start with 50 / 5 during DIVIDE -> the second request is ignored and the result is 14 r 2.
REQ-036 Start 100 / 7, assert reset at DIVIDE cycle 4 -> all outputs 0 immediately, no done pulse; a following 9 / 2 yields quotient 4, remainder 1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and defaults for the signed divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FIXUP,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_datapath.sv
// Purpose: magnitude restoring shift-subtract datapath with sign fixup and result/flag registers.
// Latency: one quotient bit per step cycle, results registered on the fix (or zero-divisor load) cycle.
// Backpressure: none; purely driven by the control strobes from the FSM.
module div_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             zload,
    input  logic             step,
    input  logic             fix,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH-1:0] raw_n;
    logic [WIDTH:0]   pr;
    logic             sign_n;
    logic             sign_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             q_bit;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             ovf_case;

    // The extra partial-remainder bit keeps a magnitude of 2^(WIDTH-1) exact.
    assign shifted  = {pr[WIDTH-1:0], work_q[WIDTH-1]};
    assign diff     = {1'b0, shifted} - {2'b00, dmag};
    assign q_bit    = ~diff[WIDTH+1];
    assign q_fix    = (sign_n ^ sign_d) ? (-work_q) : work_q;
    assign r_fix    = sign_n ? (-pr[WIDTH-1:0]) : pr[WIDTH-1:0];
    assign ovf_case = (raw_n == {1'b1, {(WIDTH-1){1'b0}}}) && sign_d && (dmag == WIDTH'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_q      <= '0;
            dmag        <= '0;
            raw_n       <= '0;
            pr          <= '0;
            sign_n      <= 1'b0;
            sign_d      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (load) begin
            work_q      <= dividend[WIDTH-1] ? (-dividend) : dividend;
            dmag        <= divisor[WIDTH-1] ? (-divisor) : divisor;
            raw_n       <= dividend;
            pr          <= '0;
            sign_n      <= dividend[WIDTH-1];
            sign_d      <= divisor[WIDTH-1];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (zload) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
        end else if (step) begin
            pr     <= q_bit ? diff[WIDTH:0] : shifted;
            work_q <= {work_q[WIDTH-2:0], q_bit};
        end else if (fix) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            overflow  <= ovf_case;
        end
    end

endmodule

// File: rtl/signed_divider.sv
// Purpose: sequential two's-complement divider (truncating), control FSM and iteration counter.
// Latency: done in the cycle after the WIDTH+1th edge past start; one cycle for a zero divisor.
// Backpressure: start is only honoured in IDLE; requests while busy or in DONE are dropped.
module signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t    state;
    div_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic          divisor_zero;
    logic          load;
    logic          zload;
    logic          step;
    logic          fix;

    assign divisor_zero = (divisor == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = divisor_zero ? DONE : DIVIDE;
            DIVIDE:  if (cnt == '0) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        done  = (state == DONE);
        load  = (state == IDLE) && start && !divisor_zero;
        zload = (state == IDLE) && start && divisor_zero;
        step  = (state == DIVIDE);
        fix   = (state == FIXUP);
    end

    // Loaded with WIDTH-1 so DIVIDE runs for exactly WIDTH cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(WIDTH - 1);
        end else if (step) begin
            cnt <= cnt - 1'b1;
        end
    end

    div_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .zload       (zload),
        .step        (step),
        .fix         (fix),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

endmodule

// File: tb/tb_signed_divider.sv
// Directed and random checks of signed_divider against a behavioural division model.
module tb_signed_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         overflow;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
    } res_t;

    res_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    signed_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t                m;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sd;
        sa = a;
        sd = b;
        m  = '0;
        if (b == '0) begin
            m.q   = '1;
            m.r   = a;
            m.dbz = 1'b1;
        end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            m.q   = a;
            m.r   = '0;
            m.ovf = 1'b1;
        end else begin
            m.q = sa / sd;
            m.r = sa % sd;
        end
        return m;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic collect(input string tag, input int want_lat);
        int   lat;
        logic busy1;
        res_t e;
        lat   = 0;
        busy1 = 1'b0;
        e     = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) busy1 = busy;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, lat, want_lat);
        check({tag, " busy"}, busy1, 1'b1);
        if (sb.size() > 0) e = sb.pop_front();
        else check({tag, " scoreboard empty"}, sb.size(), 1);
        check({tag, " quotient"}, quotient, e.q);
        check({tag, " remainder"}, remainder, e.r);
        check({tag, " div_by_zero"}, div_by_zero, e.dbz);
        check({tag, " overflow"}, overflow, e.ovf);
        @(negedge clk);
        check({tag, " done pulse width"}, done, 1'b0);
        check({tag, " quotient held"}, quotient, e.q);
        check({tag, " idle after done"}, busy, 1'b0);
    endtask

    initial begin
        int   seen;
        res_t e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset flags", {div_by_zero, overflow}, 0);
        @(negedge clk);
        reset = 1'b0;

        issue(8'd100, 8'd7);
        collect("100/7", 10);
        issue(8'h9C, 8'd7);
        collect("-100/7", 10);
        issue(8'd100, 8'hF9);
        collect("100/-7", 10);
        issue(8'h80, 8'hFF);
        collect("-128/-1", 10);
        issue(8'h80, 8'h01);
        collect("-128/1", 10);
        issue(8'h80, 8'h80);
        collect("-128/-128", 10);
        issue(8'h7F, 8'h80);
        collect("127/-128", 10);
        issue(8'd5, 8'd0);
        collect("5/0", 1);
        issue(8'h80, 8'd0);
        collect("-128/0", 1);

        // Second request during DIVIDE is dropped.
        issue(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
        collect("ignore busy start", 7);

        // Start coinciding with DONE is dropped.
        issue(8'd20, 8'd3);
        seen = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = i;
                break;
            end
        end
        check("done-cycle latency", seen, 10);
        start    = 1'b1;
        dividend = 8'd1;
        divisor  = 8'd1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        check("start in DONE ignored", busy, 1'b0);
        check("start in DONE quotient", quotient, e.q);
        check("start in DONE remainder", remainder, e.r);

        // Reset in the middle of DIVIDE.
        issue(8'd100, 8'd7);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid reset quotient", quotient, 0);
        check("mid reset remainder", remainder, 0);
        check("mid reset busy", busy, 0);
        check("mid reset done", done, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no done after reset", seen, 0);
        issue(8'd9, 8'd2);
        collect("9/2 after reset", 10);

        for (int k = 0; k < 16; k++) begin
            ra = W'($urandom);
            rb = (k % 5 == 4) ? '0 : W'($urandom);
            issue(ra, rb);
            collect($sformatf("rand %0d/%0d", $signed(ra), $signed(rb)), (rb == '0) ? 1 : 10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
